// File: rtl/accelbrot_axi_pkg.sv
// Shared AXI definitions for the accelbrot work-RAM responder: response
// codes, the burst encoding and the responder state type.
package accelbrot_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RD_BURST = 2'b01,
    ST_WR_DATA  = 2'b10,
    ST_WR_RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/accelbrot_bram_be.sv
// Single-port synchronous block RAM with per-byte write enables.
// Read data appears one cycle after an enabled access; a write cycle
// returns the word's previous contents. Contents are never reset.
module accelbrot_bram_be #(
  parameter int DEPTH = 4096,
  parameter int DW    = 128,
  parameter int NB    = DW/8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [NB-1:0] we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:DEPTH-1];

  // Byte-masked write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < NB; b++) begin
        if (we[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/accelbrot_wram_slave.sv
// AXI4 responder for the engine's work-RAM port. Serves one transaction
// at a time (read or write, INCR up to 256 beats, full width) from an
// internal byte-writable block RAM. Reads run through a 2-entry skid
// buffer so rdata/rresp/rlast are registered and hold under backpressure.
module accelbrot_wram_slave
  import accelbrot_axi_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 128,
  parameter int                        AXI_STRB_WIDTH = AXI_DATA_WIDTH/8,
  parameter int                        MEM_DEPTH      = 4096,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [AXI_ADDR_WIDTH-1:0] wram_araddr,
  input  logic [7:0]                wram_arlen,
  input  logic [2:0]                wram_arsize,
  input  logic [1:0]                wram_arburst,
  input  logic                      wram_arvalid,
  output logic                      wram_arready,
  output logic [AXI_DATA_WIDTH-1:0] wram_rdata,
  output logic                      wram_rlast,
  output logic [1:0]                wram_rresp,
  output logic                      wram_rvalid,
  input  logic                      wram_rready,
  input  logic [AXI_ADDR_WIDTH-1:0] wram_awaddr,
  input  logic [7:0]                wram_awlen,
  input  logic [2:0]                wram_awsize,
  input  logic [1:0]                wram_awburst,
  input  logic                      wram_awvalid,
  output logic                      wram_awready,
  input  logic [AXI_DATA_WIDTH-1:0] wram_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] wram_wstrb,
  input  logic                      wram_wlast,
  input  logic                      wram_wvalid,
  output logic                      wram_wready,
  output logic [1:0]                wram_bresp,
  output logic                      wram_bvalid,
  input  logic                      wram_bready
);

  localparam int NB      = AXI_DATA_WIDTH/8;
  localparam int NB_LOG2 = $clog2(NB);
  localparam int RAM_AW  = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_LIM = AXI_ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] IDX_ONE   = AXI_ADDR_WIDTH'(1);

  // Word index of a byte address; sub-word address bits are dropped and
  // addresses below BASE_ADDR wrap to huge (out-of-range) indices.
  function automatic logic [AXI_ADDR_WIDTH-1:0] to_index(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off >> NB_LOG2;
  endfunction

  state_t state, state_next;

  logic                      prio_write;
  logic [AXI_ADDR_WIDTH-1:0] idx;
  logic [8:0]                beats;
  logic [8:0]                issued;
  logic [8:0]                wr_cnt;
  logic                      wr_err;
  logic                      inflight;
  logic                      inflight_oor;
  logic                      inflight_last;
  logic [1:0]                occ;
  logic [1:0]                occ_next;
  logic [1:0]                occ_after_pop;
  logic [AXI_DATA_WIDTH-1:0] skid_data;
  logic [1:0]                skid_resp;
  logic                      skid_last;

  logic                      grant_rd;
  logic                      grant_wr;
  logic                      ar_fire;
  logic                      aw_fire;
  logic                      r_pop;
  logic                      rd_issue;
  logic                      w_fire;
  logic                      w_final;
  logic                      w_beat_err;
  logic                      b_fire;
  logic                      in_range;

  logic                      ram_en;
  logic [AXI_STRB_WIDTH-1:0] ram_we;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;
  logic [AXI_DATA_WIDTH-1:0] push_data;
  logic [1:0]                push_resp;

  // Size and burst type are accepted but not interpreted.
  logic unused_attr;
  assign unused_attr = ^{wram_arsize, wram_arburst, wram_awsize, wram_awburst};

  // Round-robin grant between AR and AW when both are pending.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (wram_arvalid && wram_awvalid) begin
      grant_wr = prio_write;
      grant_rd = !prio_write;
    end else begin
      grant_wr = wram_awvalid;
      grant_rd = wram_arvalid;
    end
  end

  assign wram_arready = (state == ST_IDLE) && grant_rd;
  assign wram_awready = (state == ST_IDLE) && grant_wr;

  assign ar_fire    = wram_arvalid && wram_arready;
  assign aw_fire    = wram_awvalid && wram_awready;
  assign r_pop      = wram_rvalid && wram_rready;
  assign w_fire     = wram_wvalid && wram_wready;
  assign b_fire     = wram_bvalid && wram_bready;
  assign in_range   = (idx < DEPTH_LIM);
  assign w_final    = (wr_cnt == (beats - 9'd1));
  assign w_beat_err = !in_range || (wram_wlast != w_final);

  // Issue a RAM read while beats remain and the skid buffer, counting the
  // entry leaving this cycle and the one still in the RAM, has room.
  always_comb begin
    occ_after_pop = occ - {1'b0, r_pop};
    if ((state == ST_RD_BURST) && (issued < beats) &&
        ((occ_after_pop + {1'b0, inflight}) < 2'd2)) begin
      rd_issue = 1'b1;
    end else begin
      rd_issue = 1'b0;
    end
  end

  // Single RAM port shared by read issue and write beats; out-of-range
  // beats never touch the array.
  always_comb begin
    ram_en = 1'b0;
    ram_we = '0;
    if (rstn && in_range && (rd_issue || w_fire)) begin
      ram_en = 1'b1;
      if (w_fire) begin
        ram_we = wram_wstrb;
      end else begin
        ram_we = '0;
      end
    end else begin
      ram_en = 1'b0;
      ram_we = '0;
    end
  end

  accelbrot_bram_be #(
    .DEPTH (MEM_DEPTH),
    .DW    (AXI_DATA_WIDTH),
    .NB    (AXI_STRB_WIDTH),
    .AW    (RAM_AW)
  ) u_bram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx[RAM_AW-1:0]),
    .wdata (wram_wdata),
    .rdata (ram_rdata)
  );

  // Beat returning from the RAM this cycle, with out-of-range beats
  // replaced by zero data and SLVERR.
  always_comb begin
    if (inflight_oor) begin
      push_data = '0;
      push_resp = RESP_SLVERR;
    end else begin
      push_data = ram_rdata;
      push_resp = RESP_OKAY;
    end
    occ_next = occ + {1'b0, inflight} - {1'b0, r_pop};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (aw_fire) begin
          state_next = ST_WR_DATA;
        end else if (ar_fire) begin
          state_next = ST_RD_BURST;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RD_BURST: begin
        if (r_pop && wram_rlast) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RD_BURST;
        end
      end
      ST_WR_DATA: begin
        if (w_fire && w_final) begin
          state_next = ST_WR_RESP;
        end else begin
          state_next = ST_WR_DATA;
        end
      end
      ST_WR_RESP: begin
        if (b_fire) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WR_RESP;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Burst bookkeeping, arbitration priority and write-channel outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio_write    <= 1'b1;
      idx           <= '0;
      beats         <= 9'd0;
      issued        <= 9'd0;
      wr_cnt        <= 9'd0;
      wr_err        <= 1'b0;
      inflight      <= 1'b0;
      inflight_oor  <= 1'b0;
      inflight_last <= 1'b0;
      wram_wready   <= 1'b0;
      wram_bvalid   <= 1'b0;
      wram_bresp    <= RESP_OKAY;
    end else begin
      inflight <= rd_issue;
      if (rd_issue) begin
        inflight_oor  <= !in_range;
        inflight_last <= (issued == (beats - 9'd1));
      end
      if (ar_fire) begin
        idx        <= to_index(wram_araddr);
        beats      <= {1'b0, wram_arlen} + 9'd1;
        issued     <= 9'd0;
        prio_write <= 1'b1;
      end else if (aw_fire) begin
        idx         <= to_index(wram_awaddr);
        beats       <= {1'b0, wram_awlen} + 9'd1;
        wr_cnt      <= 9'd0;
        wr_err      <= 1'b0;
        prio_write  <= 1'b0;
        wram_wready <= 1'b1;
      end else if (rd_issue) begin
        idx    <= idx + IDX_ONE;
        issued <= issued + 9'd1;
      end else if (w_fire) begin
        idx    <= idx + IDX_ONE;
        wr_cnt <= wr_cnt + 9'd1;
        wr_err <= wr_err || w_beat_err;
        if (w_final) begin
          wram_wready <= 1'b0;
          wram_bvalid <= 1'b1;
          wram_bresp  <= (wr_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end else if (b_fire) begin
        wram_bvalid <= 1'b0;
        wram_bresp  <= RESP_OKAY;
        wr_err      <= 1'b0;
      end
    end
  end

  // Two-entry read skid buffer; the head entry drives the R channel.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      occ         <= 2'd0;
      wram_rvalid <= 1'b0;
      wram_rdata  <= '0;
      wram_rresp  <= RESP_OKAY;
      wram_rlast  <= 1'b0;
      skid_data   <= '0;
      skid_resp   <= RESP_OKAY;
      skid_last   <= 1'b0;
    end else begin
      case ({inflight, r_pop})
        2'b10: begin
          if (occ == 2'd0) begin
            wram_rdata <= push_data;
            wram_rresp <= push_resp;
            wram_rlast <= inflight_last;
          end else begin
            skid_data <= push_data;
            skid_resp <= push_resp;
            skid_last <= inflight_last;
          end
        end
        2'b01: begin
          wram_rdata <= skid_data;
          wram_rresp <= skid_resp;
          wram_rlast <= skid_last;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            wram_rdata <= push_data;
            wram_rresp <= push_resp;
            wram_rlast <= inflight_last;
          end else begin
            wram_rdata <= skid_data;
            wram_rresp <= skid_resp;
            wram_rlast <= skid_last;
            skid_data  <= push_data;
            skid_resp  <= push_resp;
            skid_last  <= inflight_last;
          end
        end
        default: begin
        end
      endcase
      occ         <= occ_next;
      wram_rvalid <= (occ_next != 2'd0);
    end
  end

endmodule

// File: tb/tb_accelbrot_wram_slave.sv
// Directed bench for accelbrot_wram_slave: single-beat and burst traffic,
// read backpressure, partial strobes, error responses, reset mid-burst
// and AR/AW arbitration. Expected values are written out by hand.
module tb_accelbrot_wram_slave;

  logic         clk;
  logic         rstn;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [127:0] rdata;
  logic         rlast;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  int total;
  int bad;

  logic [127:0] rd_data [0:31];
  logic [1:0]   rd_resp [0:31];
  logic         rd_last [0:31];
  int           rd_n;
  int           rd_first;
  int           rd_lastc;
  int           rd_stall_bad;
  int           rd_stalls;
  int           ar_wait;
  logic [1:0]   wr_resp;
  int           wr_bdelay;

  localparam logic [127:0] D_SINGLE = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] D_BURST  = 128'h1000_0000_2000_0000_3000_0000_0000_0000;
  localparam logic [127:0] D_ERR    = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D_ARB    = 128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A;

  accelbrot_wram_slave dut (
    .clk          (clk),
    .rstn         (rstn),
    .wram_araddr  (araddr),
    .wram_arlen   (arlen),
    .wram_arsize  (arsize),
    .wram_arburst (arburst),
    .wram_arvalid (arvalid),
    .wram_arready (arready),
    .wram_rdata   (rdata),
    .wram_rlast   (rlast),
    .wram_rresp   (rresp),
    .wram_rvalid  (rvalid),
    .wram_rready  (rready),
    .wram_awaddr  (awaddr),
    .wram_awlen   (awlen),
    .wram_awsize  (awsize),
    .wram_awburst (awburst),
    .wram_awvalid (awvalid),
    .wram_awready (awready),
    .wram_wdata   (wdata),
    .wram_wstrb   (wstrb),
    .wram_wlast   (wlast),
    .wram_wvalid  (wvalid),
    .wram_wready  (wready),
    .wram_bresp   (bresp),
    .wram_bvalid  (bvalid),
    .wram_bready  (bready)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input int nbeats, input logic [127:0] d0,
                           input logic [15:0] strb, input int bad_last);
    bit ok;
    awaddr  = addr;
    awlen   = 8'(nbeats - 1);
    awvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = awready;
      @(posedge clk);
      #1;
    end
    awvalid = 1'b0;
    if (!ok) begin
      check_val("aw_handshake_timeout", 128'd0, 128'd1);
      return;
    end
    for (int i = 0; i < nbeats; i++) begin
      wdata  = d0 + 128'(i);
      wstrb  = strb;
      wlast  = (i == nbeats - 1) ^ (i == bad_last);
      wvalid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
        @(negedge clk);
        ok = wready;
        @(posedge clk);
        #1;
      end
      if (!ok) begin
        wvalid = 1'b0;
        check_val("w_handshake_timeout", 128'd0, 128'd1);
        return;
      end
    end
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b1;
    ok        = 1'b0;
    wr_bdelay = 0;
    wr_resp   = 2'bxx;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bvalid;
      if (ok) wr_resp = bresp;
      else wr_bdelay++;
      @(posedge clk);
      #1;
    end
    bready = 1'b0;
    if (!ok) check_val("b_timeout", 128'd0, 128'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int nbeats, input bit bp);
    bit ok;
    bit done;
    bit stalled;
    logic [127:0] hold_d;
    logic [1:0]   hold_r;
    logic         hold_l;
    rd_n = 0; rd_first = -1; rd_lastc = -1; rd_stall_bad = 0; rd_stalls = 0; ar_wait = 0;
    hold_d = '0; hold_r = 2'b00; hold_l = 1'b0;
    araddr  = addr;
    arlen   = 8'(nbeats - 1);
    arvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = arready;
      if (!ok) ar_wait++;
      @(posedge clk);
      #1;
    end
    arvalid = 1'b0;
    if (!ok) begin
      check_val("ar_handshake_timeout", 128'd0, 128'd1);
      return;
    end
    done = 1'b0;
    stalled = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      rready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (stalled) begin
        if (!rvalid || rdata !== hold_d || rresp !== hold_r || rlast !== hold_l) rd_stall_bad++;
      end
      if (rvalid) begin
        if (rd_first < 0) rd_first = c;
        if (rready) begin
          if (rd_n < 32) begin
            rd_data[rd_n] = rdata;
            rd_resp[rd_n] = rresp;
            rd_last[rd_n] = rlast;
          end
          rd_n++;
          if (rlast) begin
            done = 1'b1;
            rd_lastc = c;
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          rd_stalls++;
          hold_d = rdata;
          hold_r = rresp;
          hold_l = rlast;
        end
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    rready = 1'b0;
    if (!done) check_val("r_last_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    logic [127:0] exp_strb;
    int errs;
    total = 0; bad = 0;
    rstn = 1'b0;
    araddr = 32'd0; arlen = 8'd0; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    awaddr = 32'd0; awlen = 8'd0; awsize = 3'd4; awburst = 2'b01; awvalid = 1'b0;
    wdata = 128'd0; wstrb = 16'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset state.
    @(negedge clk);
    check_val("rst_arready", arready, 1'b0);
    check_val("rst_awready", awready, 1'b0);
    check_val("rst_wready",  wready,  1'b0);
    check_val("rst_rvalid",  rvalid,  1'b0);
    check_val("rst_bvalid",  bvalid,  1'b0);
    check_val("rst_rdata",   rdata,   128'd0);
    check_val("rst_rresp",   rresp,   2'b00);
    check_val("rst_bresp",   bresp,   2'b00);
    @(posedge clk);
    #1;

    // Single-beat write then read.
    axi_write(32'h0000_0040, 1, D_SINGLE, 16'hFFFF, -1);
    check_val("single_bresp",  wr_resp,   2'b00);
    check_val("single_bdelay", wr_bdelay, 0);
    axi_read(32'h0000_0040, 1, 1'b0);
    check_val("single_rn",     rd_n,       1);
    check_val("single_rdata",  rd_data[0], D_SINGLE);
    check_val("single_rlast",  rd_last[0], 1'b1);
    check_val("single_rresp",  rd_resp[0], 2'b00);
    check_val("single_rfirst", rd_first,   2);

    // 16-beat burst, full-rate read.
    axi_write(32'h0000_1000, 16, D_BURST, 16'hFFFF, -1);
    check_val("burst_bresp", wr_resp, 2'b00);
    axi_read(32'h0000_1000, 16, 1'b0);
    check_val("burst_rn",     rd_n, 16);
    check_val("burst_span",   rd_lastc - rd_first, 15);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (rd_data[i] !== D_BURST + 128'(i) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 15)) errs++;
    end
    check_val("burst_beats", errs, 0);

    // Same burst under 1-0-0-1 backpressure.
    axi_read(32'h0000_1000, 16, 1'b1);
    check_val("bp_rn", rd_n, 16);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      if (rd_data[i] !== D_BURST + 128'(i) || rd_last[i] !== (i == 15)) errs++;
    end
    check_val("bp_beats",     errs,         0);
    check_val("bp_stable",    rd_stall_bad, 0);
    check_val("bp_had_stall", rd_stalls > 0, 1'b1);

    // Partial strobe over an all-ones word.
    axi_write(32'h0000_2000, 1, ~128'd0, 16'hFFFF, -1);
    axi_write(32'h0000_2000, 1, 128'd0,  16'h00F0, -1);
    exp_strb = ~128'd0;
    exp_strb[63:32] = 32'd0;
    axi_read(32'h0000_2000, 1, 1'b0);
    check_val("strb_rdata", rd_data[0], exp_strb);

    // Burst crossing the top of memory.
    axi_write(32'h0000_FFF0, 2, D_ERR, 16'hFFFF, -1);
    check_val("oor_bresp", wr_resp, 2'b10);
    axi_read(32'h0000_FFF0, 2, 1'b0);
    check_val("oor_rn",     rd_n,       2);
    check_val("oor_d0",     rd_data[0], D_ERR);
    check_val("oor_r0",     rd_resp[0], 2'b00);
    check_val("oor_d1",     rd_data[1], 128'd0);
    check_val("oor_r1",     rd_resp[1], 2'b10);
    check_val("oor_rlast1", rd_last[1], 1'b1);

    // wlast protocol errors; data still lands, error clears after B.
    axi_write(32'h0000_3000, 4, D_BURST, 16'hFFFF, 1);
    check_val("early_wlast_bresp", wr_resp, 2'b10);
    axi_write(32'h0000_3100, 1, D_SINGLE, 16'hFFFF, -1);
    check_val("sticky_cleared_bresp", wr_resp, 2'b00);
    axi_write(32'h0000_3200, 2, D_SINGLE, 16'hFFFF, 1);
    check_val("missing_wlast_bresp", wr_resp, 2'b10);
    axi_read(32'h0000_3000, 4, 1'b0);
    check_val("early_wlast_data3", rd_data[3], D_BURST + 128'd3);

    // Reset in the middle of a read burst.
    araddr = 32'h0000_1000; arlen = 8'd15; arvalid = 1'b1;
    @(negedge clk);
    check_val("mid_rst_arready", arready, 1'b1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check_val("mid_rst_rvalid", rvalid, 1'b0);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rvalid) errs++;
    end
    check_val("mid_rst_no_beats", errs, 0);
    rready = 1'b0;
    @(posedge clk);
    #1;

    // Simultaneous AR and AW straight out of reset: write wins.
    awaddr = 32'h0000_5000; awlen = 8'd0; awvalid = 1'b1;
    araddr = 32'h0000_5000; arlen = 8'd0; arvalid = 1'b1;
    @(negedge clk);
    check_val("arb_awready", awready, 1'b1);
    check_val("arb_arready", arready, 1'b0);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wdata = D_ARB; wstrb = 16'hFFFF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check_val("arb_wready",       wready,  1'b1);
    check_val("arb_rd_stalled_w", arready, 1'b0);
    @(posedge clk);
    #1;
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge clk);
    check_val("arb_bvalid",       bvalid,  1'b1);
    check_val("arb_rd_stalled_b", arready, 1'b0);
    @(posedge clk);
    #1;
    bready = 1'b0;
    axi_read(32'h0000_5000, 1, 1'b0);
    check_val("arb_ar_wait", ar_wait,    0);
    check_val("arb_rdata",   rd_data[0], D_ARB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/accelbrot_wram_slave.md
Name: accelbrot_wram_slave

Overview:
- AXI4 responder (slave) for the engine's work-RAM master port: accepts AR/R and AW/W/B traffic and serves it from an internal synchronous block RAM.
- Connects directly to the engine's wram_* signals.
- Serves as the on-chip pixel/work buffer in small configurations and as the bus-accurate memory model in engine-level benches.
- Handles one transaction at a time (read or write) with INCR bursts of up to 256 beats.

Parameters:
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 128, data width; bytes per beat NB = AXI_DATA_WIDTH/8.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, write strobe width.
- MEM_DEPTH, 4096, RAM depth in AXI_DATA_WIDTH words (power of two).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- wram_araddr  in  AXI_ADDR_WIDTH  read address
- wram_arlen  in  8  read beats minus 1
- wram_arsize  in  3  read beat size
- wram_arburst  in  2  read burst type
- wram_arvalid  in  1  AR valid
- wram_arready  out  1  AR ready
- wram_rdata  out  AXI_DATA_WIDTH  read data
- wram_rlast  out  1  last read beat
- wram_rresp  out  2  read response
- wram_rvalid  out  1  R valid
- wram_rready  in  1  R ready
- wram_awaddr  in  AXI_ADDR_WIDTH  write address
- wram_awlen  in  8  write beats minus 1
- wram_awsize  in  3  write beat size
- wram_awburst  in  2  write burst type
- wram_awvalid  in  1  AW valid
- wram_awready  out  1  AW ready
- wram_wdata  in  AXI_DATA_WIDTH  write data
- wram_wstrb  in  AXI_STRB_WIDTH  byte enables
- wram_wlast  in  1  last write beat
- wram_wvalid  in  1  W valid
- wram_wready  out  1  W ready
- wram_bresp  out  2  write response
- wram_bvalid  out  1  B valid
- wram_bready  in  1  B ready

Behaviour:
- Reset (rstn low at a clk edge): state IDLE; all ready/valid outputs 0, rdata 0, rlast 0, rresp/bresp 2'b00; priority flag = write-first. RAM contents are not reset.
- Reset mid-burst: the burst is aborted, no further beats, no B response.
- States: IDLE, RD_BURST, WR_DATA, WR_RESP.
- IDLE, ready generation: arready/awready are combinational from IDLE and the arbiter grant.
- IDLE, arbitration: with only one valid, that request is granted. With arvalid and awvalid both high, grant the type not granted last (round-robin); first ever grant is write.
- IDLE, on AR handshake: latch index = ((araddr-BASE_ADDR) >> log2(NB)) and beats = arlen+1; go to RD_BURST.
- IDLE, on AW handshake: latch the same fields from awaddr/awlen; go to WR_DATA. Low address bits below NB are ignored.
- Burst attributes: arsize/awsize and burst type are not checked; every burst is treated as INCR at full width.
- Address range: a beat whose index is >= MEM_DEPTH (pre-wrap) is out of range.
- Read out-of-range beat: returns rdata 0 with rresp 2'b10 (SLVERR).
- Write out-of-range beat: dropped and sets sticky error; bresp becomes 2'b10.
- In-range beats: index increments by 1 per beat and never wraps inside range.
- RD_BURST, pipeline: RAM read latency is 1 cycle. A 2-entry output skid buffer sits behind the RAM. A RAM read issues when the issued beat count < beats and skid occupancy + in-flight count < 2.
- RD_BURST, timing: first rvalid arrives 2 cycles after the AR handshake. Sustained throughput is 1 beat/cycle with rready=1.
- RD_BURST, backpressure: rdata/rresp/rlast stay stable while rvalid && !rready.
- RD_BURST, completion: rlast=1 exactly on beat number beats. After the rlast handshake, go to IDLE; the next AR/AW is accepted in the following cycle.
- WR_DATA: wready=1. Each wvalid beat writes the RAM bytes with wstrb set; bytes with wstrb clear are unchanged. The beat counter, not wlast, ends the burst.
- WR_DATA, wlast errors: wlast on a non-final beat, or wlast=0 on the final beat, sets sticky error (bresp 2'b10); the data is still written.
- WR_DATA to WR_RESP: after the final beat, go to WR_RESP; bvalid rises the next cycle.
- WR_RESP: bvalid held with bresp until bready; then go to IDLE and clear the sticky error.
- Simultaneous events: a W beat arriving before the AW handshake is not accepted, since wready=0 outside WR_DATA. A read issued during an open write burst is stalled until the B handshake.
- Read-after-write: a read that follows a write B handshake returns the written data.

Decomposition:
- Shared package accelbrot_axi_pkg holds:
  - the resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - the burst constant BURST_INCR=2'b01;
  - the slave state_t enum.
- Sub-module accelbrot_bram_be: single-port synchronous RAM, MEM_DEPTH x AXI_DATA_WIDTH, byte-write enables, 1-cycle read latency.

Test Plan:
- Single-beat write then read: AW addr 0x40 len 0, wdata 0x0123..CDEF, wstrb all 1 -> bresp 00, bvalid 1 cycle after the W beat. Then AR 0x40 len 0 -> same data, rlast=1, rresp 00, rvalid 2 cycles after AR.
- Burst with rready=1: write 16 beats of incrementing words from 0x1000, then AR len 15 -> 16 consecutive-cycle beats, values matching, rlast only on beat 16.
- Backpressure: same 16-beat read with rready toggling 1-0-0-1 -> no beat lost or duplicated, rdata stable while stalled.
- Partial strobe: pre-fill 0xFF.., then write wstrb 16'h00F0 with data 0 -> read returns bytes 4-7 zero, all other bytes 0xFF.
- Error handling: AW at index MEM_DEPTH-1 len 1 -> first beat written, bresp 10. A separate burst with wlast asserted early -> bresp 10.
- Arbitration and reset: arvalid and awvalid both high from reset -> write granted first, then read. Assert rstn low mid read burst -> rvalid 0 next cycle, state IDLE, new AR accepted.
